csa_cpa_resolve: RTL



---
 rtl/csa_cpa_resolve_if.sv | 34 +++
 rtl/csa_cpa_resolve.sv | 97 +++++++++
 2 files changed

// File: rtl/csa_cpa_resolve_if.sv
// ---------------------------------------------------------------------------
// csa_cpa_resolve_if
// Handshake bundle between the 3:2 carry-save stage, the digit-serial
// carry-propagate resolver and its consumer.
//   in_valid / in_ready : capture of one (g, f) carry-save pair
//   g, f                : sum vector (weight 2^i), carry vector (weight 2^(i+1))
//   out_valid/out_ready : delivery of the resolved sum
//   sum                 : binary g + 2*f, RW = W+2 bits
//   busy                : resolver is adding digits
// Modports: slave = resolver side, master = upstream/downstream side.
// ---------------------------------------------------------------------------
interface csa_cpa_resolve_if #(
    parameter int W  = 74,
    parameter int RW = W + 2
);
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  g;
    logic [W-1:0]  f;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] sum;
    logic          busy;

    modport slave (
        input  in_valid, g, f, out_ready,
        output in_ready, out_valid, sum, busy
    );

    modport master (
        output in_valid, g, f, out_ready,
        input  in_ready, out_valid, sum, busy
    );
endinterface

// File: rtl/csa_cpa_resolve.sv
// ---------------------------------------------------------------------------
// csa_cpa_resolve
// Digit-serial carry-propagate adder behind the 3:2 compression stage.
// Captures one carry-save pair (g, f) and resolves g + 2*f, D bits per
// cycle over NDIG cycles, then holds the result until consumed.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset
//   bus  : csa_cpa_resolve_if.slave (in_valid/in_ready/g/f,
//          out_valid/out_ready/sum, busy)
// ---------------------------------------------------------------------------
module csa_cpa_resolve #(
    parameter int N = 222,
    parameter int D = 16
) (
    input  logic                clk,
    input  logic                rst,
    csa_cpa_resolve_if.slave    bus
);
    localparam int W    = N / 3;
    localparam int RW   = W + 2;
    localparam int NDIG = (RW + D - 1) / D;
    localparam int PW   = NDIG * D;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t          r_state, w_state_nxt;
    logic [PW-1:0]   r_opa, r_opb, r_acc;
    logic            r_carry;
    logic [CW-1:0]   r_cnt;
    logic [RW-1:0]   r_sum;

    logic [D:0]      w_t;
    logic [PW-1:0]   w_acc_nxt;
    logic            w_last;

    // One digit of the ripple: D+1 bits wide so the carry-out lands in w_t[D].
    assign w_t = {1'b0, r_opa[D-1:0]} + {1'b0, r_opb[D-1:0]} + {{D{1'b0}}, r_carry};

    // Accumulator fills from the top; after NDIG digits digit 0 sits at bit 0.
    assign w_acc_nxt = (r_acc >> D) | (PW'(w_t[D-1:0]) << (PW - D));
    assign w_last    = (r_cnt == CW'(NDIG - 1));

    // Outputs are decoded from registered state only.
    assign bus.in_ready  = (r_state == IDLE);
    assign bus.busy      = (r_state == ADD);
    assign bus.out_valid = (r_state == DONE);
    assign bus.sum       = r_sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.in_valid) w_state_nxt = ADD;
            ADD:     if (w_last)       w_state_nxt = DONE;
            DONE:    if (bus.out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_opa   <= '0;
            r_opb   <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
        end else begin
            case (r_state)
                IDLE: if (bus.in_valid) begin
                    r_opa   <= PW'(bus.g);
                    // f carries weight 2^(i+1): pre-shift left by one.
                    r_opb   <= PW'({bus.f, 1'b0});
                    r_acc   <= '0;
                    r_carry <= 1'b0;
                    r_cnt   <= '0;
                end
                ADD: begin
                    r_acc   <= w_acc_nxt;
                    r_carry <= w_t[D];
                    r_opa   <= r_opa >> D;
                    r_opb   <= r_opb >> D;
                    r_cnt   <= r_cnt + CW'(1);
                    // Padding above RW is always zero and is dropped here.
                    if (w_last) r_sum <= w_acc_nxt[RW-1:0];
                end
                default: ;
            endcase
        end
    end
endmodule
